ram_burst_reader: RTL and testbench
===================================

# ram_burst_reader

Single-clock read engine for `simple_dual_port_ram`: given a start address and a word count, it drives the RAM read port and streams the returned words out over a valid/ready interface. It absorbs the RAM's one-cycle read latency and downstream backpressure with an internal 2-entry output buffer, so no word is lost or duplicated. It sits on the read side of a RAM whose write side is filled by a separate producer, with both sides sharing one clock.

## Interface

- `WIDTH`, default 8: word width; must match the RAM.
- `ENTRIES`, default 8: RAM depth. `AW = $clog2(ENTRIES)`.
- `clk` in 1: clock; also drives the RAM's `rclk`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a burst; sampled only while idle.
- `start_addr` in AW: first RAM address of the burst.
- `count` in AW+1: words to read, 0..ENTRIES; values above ENTRIES are clamped to ENTRIES.
- `busy` out 1: a burst is in progress.
- `done` out 1: one-cycle pulse when the burst's last word has been handshaken.
- `raddr` out AW: address to the RAM read port.
- `read_data` in WIDTH: RAM output; holds `mem[raddr]` as sampled at the previous edge.
- `out_data` out WIDTH: streamed word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the word; a transfer occurs when `out_valid & out_ready`.

## Operation

- **States:** IDLE, READ, DRAIN.
- **IDLE:**
  - `start=1` with `count>0` latches `start_addr` and `count`, then goes to READ.
  - `start=1` with `count=0` pulses `done` on the next cycle and stays in IDLE. No RAM read is issued and no output is produced.
- **READ:**
  - Each cycle the engine decides `issue`. When `issue=1`, `raddr` carries the current address, the address increments, and the remaining count decrements.
  - Issue rule: `issue = remaining>0 && (buf_count + inflight - pop) < 2`.
    - `inflight` is 1 if a read was issued in the previous cycle.
    - `pop` is `out_valid & out_ready` in the current cycle.
  - The buffer therefore never overflows, and sustained throughput is one word per cycle while `out_ready=1`.
  - The address wraps from ENTRIES-1 to 0, which also holds for ENTRIES values that are not a power of two.
  - When `remaining` reaches 0, the engine goes to DRAIN.
- **Capture:** in the cycle after an issue, `read_data` is written into the 2-entry FIFO. The FIFO head drives `out_data`/`out_valid`.
- **DRAIN:** no further issues. When the last word is handshaken, `done` pulses on the next cycle and the engine returns to IDLE.
- **`busy`:** 1 in READ and DRAIN, 0 in IDLE, including the cycle in which `done` pulses.
- **`start` while busy:** ignored, with no effect on the running burst.
- **A new `start` in the `done` cycle:** accepted normally.
- **Output ordering:** words are output strictly in address order, each exactly once.
- **Stability:** while `out_valid=1` and `out_ready=0`, `out_data` and `out_valid` hold stable.
- **Reset (asynchronous, mid-burst included):**
  - State goes to IDLE and the FIFO empties.
  - Any in-flight read is discarded.
  - `busy`, `done` and `out_valid` go to 0, and `raddr` and `out_data` go to 0.
- **Write-side collisions:** the block takes no part in the RAM's write side. Collisions between writes and reads at the same address are the system's responsibility.

## Timing

- **Start to first output:** with `start` sampled at edge 0:
  - cycle 1: `raddr = start_addr` and issue.
  - cycle 2: `read_data` is valid and is captured at the end of the cycle.
  - cycle 3: `out_valid = 1`.
- **Burst of N words, `out_ready` held 1:** `out_valid` is high in cycles 3..N+2, and `done` pulses in cycle N+3.
- **Backpressure:**
  - After `out_ready` falls, at most 2 words are buffered and issue stops.
  - Issue resumes in the same cycle that `out_ready` returns, because `pop` is counted.
  - The result is no bubble beyond the inherent one-cycle read latency.
- **When `raddr` is don't-care:** in cycles with `issue=0`. The implementation holds the last value.
- **Registered outputs:** `out_valid`, `out_data`, `busy` and `done` are registered. `raddr` is taken directly from the address register, so it is also a register output.

## Test plan

- Preload RAM[i] = 8'hA0+i, then `start` with start_addr=2 and count=4, `out_ready`=1 → `out_data` reads A2, A3, A4, A5 in cycles 3-6, `done` pulses in cycle 7, and `busy` is high in cycles 1-6.
- Wrap: start_addr=6 and count=4 with ENTRIES=8 → outputs A6, A7, A0, A1.
- Backpressure: count=8 with `out_ready` toggled randomly, including holds of 5 or more cycles → all 8 words appear in order with no duplicates, `out_data` is stable while stalled, and no more than 2 reads are outstanding at any time.
- Edge cases:
  - count=0 → `done` pulses in cycle 1, with `out_valid` never high and `busy` never high.
  - count=9 → behaves as 8 words.
  - `start` pulsed mid-burst → ignored.
- Reset: assert `rst_n`=0 asynchronously mid-burst with 2 words buffered → all outputs are 0 immediately. After release, a new burst with count=2 returns the correct 2 words with no stale data.

Source files
------------

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams a burst of words out of a simple_dual_port_ram
// read port onto a valid/ready interface. A 2-entry output buffer (head +
// skid register) absorbs the RAM's one-cycle read latency and downstream
// backpressure. Reads are only issued when a buffer slot is guaranteed to
// be free by the time the data returns.
module ram_burst_reader #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 8,
  localparam int AW     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] read_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    addr_reg;
  logic [AW:0]      remaining_reg;
  logic             inflight_reg;
  logic [WIDTH-1:0] head_data_reg, skid_data_reg;
  logic             head_valid_reg, skid_valid_reg;
  logic             done_reg, busy_reg;

  logic [WIDTH-1:0] head_data_next, skid_data_next;
  logic             head_valid_next, skid_valid_next;
  logic             done_next;
  logic             load;
  logic             issue;
  logic             pop;
  logic [1:0]       buf_count;
  logic [2:0]       occupancy;
  logic [2:0]       occ_limit;
  logic [AW:0]      count_clamped;
  logic [AW-1:0]    addr_inc;

  assign raddr     = addr_reg;
  assign out_data  = head_data_reg;
  assign out_valid = head_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  assign pop       = head_valid_reg & out_ready;
  assign buf_count = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};
  // Words that will be sitting in the buffer after this edge if we issue
  // nothing: buffered + returning read - word leaving now. Issue only when
  // that leaves room for one more.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_reg};
  assign occ_limit = 3'd2 + {2'b00, pop};
  assign issue     = (state_reg == READ) && (remaining_reg != '0) && (occupancy < occ_limit);

  assign count_clamped = (count > (AW+1)'(ENTRIES)) ? (AW+1)'(ENTRIES) : count;
  // Explicit wrap so non-power-of-two depths stay inside the RAM.
  assign addr_inc      = (addr_reg == AW'(ENTRIES - 1)) ? '0 : addr_reg + 1'b1;

  // Next-state and done decision; burst ends when the final buffered word leaves.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            load       = 1'b1;
            state_next = READ;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      READ: begin
        if (issue && (remaining_reg == (AW+1)'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (buf_count == 2'd1) && !inflight_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output buffer update: drop the head on a pop, append returning RAM data at the tail.
  always_comb begin
    head_data_next  = head_data_reg;
    head_valid_next = head_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;
    if (pop) begin
      if (skid_valid_reg) begin
        head_data_next  = skid_data_reg;
        head_valid_next = 1'b1;
        skid_valid_next = inflight_reg;
        if (inflight_reg) begin
          skid_data_next = read_data;
        end
      end else begin
        head_valid_next = inflight_reg;
        if (inflight_reg) begin
          head_data_next = read_data;
        end
      end
    end else if (inflight_reg) begin
      if (!head_valid_reg) begin
        head_data_next  = read_data;
        head_valid_next = 1'b1;
      end else begin
        skid_data_next  = read_data;
        skid_valid_next = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address/count tracking, in-flight flag, buffer and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg       <= '0;
      remaining_reg  <= '0;
      inflight_reg   <= 1'b0;
      head_data_reg  <= '0;
      head_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      if (load) begin
        addr_reg      <= start_addr;
        remaining_reg <= count_clamped;
      end else if (issue) begin
        addr_reg      <= addr_inc;
        remaining_reg <= remaining_reg - 1'b1;
      end
      inflight_reg   <= issue;
      head_data_reg  <= head_data_next;
      head_valid_reg <= head_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
      done_reg       <= done_next;
      busy_reg       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural synchronous-read RAM.
module tb_ram_burst_reader;

  localparam int WIDTH   = 8;
  localparam int ENTRIES = 8;
  localparam int AW      = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    start_addr;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  logic [WIDTH-1:0] mem [ENTRIES];

  int n_vec  = 0;
  int n_miss = 0;

  ram_burst_reader #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .read_data  (read_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // RAM read port: registered read of mem[raddr].
  always @(posedge clk) read_data <= mem[raddr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one burst; caller is aligned 1 time unit after a rising edge.
  task automatic run_burst(input string tag, input int sa, input int cnt, input int n_exp,
                           input bit bp, input bit midstart);
    bit [63:0]  pat;
    logic [7:0] got [16];
    logic [7:0] exp_w;
    logic [7:0] prev_data;
    logic [AW-1:0] prev_raddr;
    bit  stalled;
    bit  ready_now;
    int  n, issues, pops, done_cnt, cyc;
    pat = 64'hF03F_0E7C_81F3_C5A7;
    n = 0; issues = 0; pops = 0; done_cnt = 0; stalled = 0; prev_data = '0;
    start_addr = AW'(sa);
    count      = (AW+1)'(cnt);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, " raddr_c1"}, 32'(raddr), 32'(sa));
    prev_raddr = raddr;
    for (cyc = 1; cyc < 300; cyc++) begin
      start = 1'b0;
      if (stalled) begin
        check_val({tag, " stall_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, " stall_data"}, 32'(out_data), 32'(prev_data));
      end
      if (raddr != prev_raddr) issues++;
      prev_raddr = raddr;
      check_val({tag, " outstanding_le2"}, 32'((issues - pops) <= 2), 32'd1);
      if (done) begin
        done_cnt++;
        check_val({tag, " busy_at_done"}, 32'(busy), 32'd0);
        break;
      end
      ready_now = bp ? pat[cyc % 64] : 1'b1;
      out_ready = ready_now;
      if (midstart && cyc == 4) begin
        start_addr = '0;
        count      = (AW+1)'(1);
        start      = 1'b1;
      end
      if (out_valid && ready_now) begin
        if (n < 16) got[n] = out_data;
        n++;
        pops++;
      end
      stalled   = out_valid && !ready_now;
      prev_data = out_data;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_val({tag, " done_seen"}, 32'(done_cnt), 32'd1);
    check_val({tag, " word_count"}, 32'(n), 32'(n_exp));
    check_val({tag, " issue_count"}, 32'(issues), 32'(n_exp));
    for (int i = 0; i < n_exp && i < n && i < 16; i++) begin
      exp_w = 8'hA0 + 8'((sa + i) % ENTRIES);
      check_val($sformatf("%s word%0d", tag, i), 32'(got[i]), 32'(exp_w));
    end
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) mem[i] = 8'hA0 + 8'(i);
    rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b0;
    #12;
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst out_valid", 32'(out_valid), 32'd0);
    check_val("rst raddr", 32'(raddr), 32'd0);
    check_val("rst out_data", 32'(out_data), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle-exact burst: start_addr=2, count=4, ready held high.
    start_addr = 3'd2; count = 4'd4; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("t1 raddr_c1", 32'(raddr), 32'd2);
    for (int c = 1; c <= 8; c++) begin
      check_val($sformatf("t1 busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 6));
      check_val($sformatf("t1 valid c%0d", c), 32'(out_valid), 32'(c >= 3 && c <= 6));
      check_val($sformatf("t1 done c%0d", c), 32'(done), 32'(c == 7));
      if (c >= 3 && c <= 6)
        check_val($sformatf("t1 data c%0d", c), 32'(out_data), 32'(8'hA2 + 8'(c - 3)));
      @(posedge clk); #1;
    end

    run_burst("wrap", 6, 4, 4, 1'b0, 1'b0);
    run_burst("bp8", 0, 8, 8, 1'b1, 1'b0);
    run_burst("cnt9", 3, 9, 8, 1'b0, 1'b0);
    run_burst("midstart", 4, 5, 5, 1'b1, 1'b1);

    // count=0: done in cycle 1, never busy, never valid.
    out_ready = 1'b1; start_addr = 3'd1; count = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("cnt0 done_c1", 32'(done), 32'd1);
    check_val("cnt0 busy_c1", 32'(busy), 32'd0);
    check_val("cnt0 valid_c1", 32'(out_valid), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      check_val($sformatf("cnt0 done c%0d", c), 32'(done), 32'd0);
      check_val($sformatf("cnt0 busy c%0d", c), 32'(busy), 32'd0);
      check_val($sformatf("cnt0 valid c%0d", c), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-burst with the buffer full.
    out_ready = 1'b0; start_addr = 3'd1; count = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check_val("pre_rst valid", 32'(out_valid), 32'd1);
    check_val("pre_rst data", 32'(out_data), 32'hA1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst busy", 32'(busy), 32'd0);
    check_val("async_rst done", 32'(done), 32'd0);
    check_val("async_rst valid", 32'(out_valid), 32'd0);
    check_val("async_rst raddr", 32'(raddr), 32'd0);
    check_val("async_rst data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst("post_rst", 5, 2, 2, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check_val("post_rst idle_valid", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
